// File: rtl/sha_padder.sv
`default_nettype none
// sha_padder: AXI-Stream SHA-224/256/384/512 message padder (64-byte beats in, padded blocks out).
// Revision 1.0 - initial release.
module sha_padder #(
  parameter int S_AXIS_DATA_WIDTH  = 512,
  parameter int M_AXIS_DATA_WIDTH  = 1024,
  parameter int S_AXIS_TUSER_WIDTH = 128,
  parameter int M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);

  localparam int KB = S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,
    EMIT       = 2'd1,
    EMIT_EXTRA = 2'd2
  } state_t;

  state_t state, state_n;

  logic                          alive;
  logic                          in_msg;
  logic [1:0]                    type_q;
  logic [M_AXIS_TUSER_WIDTH-1:0] tuser_q;
  logic                          beat_idx;
  logic [63:0]                   byte_cnt;
  logic [1023:0]                 blk;       // block byte j always kept at [1023-8j -: 8]
  logic                          last_q;
  logic                          extra_q;
  logic                          marker_q;

  logic          beat_acc;
  logic          blk_acc;
  logic          msg_done;
  logic [1:0]    type_eff;
  logic          big;
  logic [6:0]    nbytes;
  logic [7:0]    p;
  logic [7:0]    bsize;
  logic [7:0]    lfield;
  logic [63:0]   cnt_n;
  logic [63:0]   len_n;
  logic          complete;
  logic          extra_n;
  logic [1023:0] blk_n;
  logic [1023:0] extra_blk;

  assign s_axis_tready = alive && (state == COLLECT);
  assign m_axis_tvalid = (state != COLLECT);
  assign m_axis_tlast  = m_axis_tvalid && last_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tdata  = type_q[1] ? blk : {512'd0, blk[1023:512]};

  assign beat_acc = s_axis_tvalid && s_axis_tready;
  assign blk_acc  = m_axis_tvalid && m_axis_tready;
  assign msg_done = blk_acc && last_q;

  always_comb begin
    type_eff = in_msg ? type_q : s_axis_tuser[33:32];
    big      = type_eff[1];
    nbytes   = '0;
    for (int k = 0; k < KB; k++) begin
      nbytes = nbytes + 7'(s_axis_tkeep[k]);
    end
    p        = beat_idx ? (8'd64 + {1'b0, nbytes}) : {1'b0, nbytes};
    bsize    = big ? 8'd128 : 8'd64;
    lfield   = big ? 8'd112 : 8'd56;
    cnt_n    = byte_cnt + 64'(nbytes);
    len_n    = {cnt_n[60:0], 3'b000};
    complete = s_axis_tlast || !big || beat_idx;
    extra_n  = s_axis_tlast && (p >= lfield);

    // The first beat of a block starts from zero so short SHA-384/512 tails never expose stale bytes.
    blk_n = beat_idx ? blk : '0;
    for (int j = 0; j < 128; j++) begin
      if (((j >= 64) == beat_idx) && s_axis_tkeep[j % 64]) begin
        blk_n[1023-8*j -: 8] = s_axis_tdata[8*(j % 64) +: 8];
      end
      if (s_axis_tlast && (8'(j) == p) && (p < bsize)) begin
        blk_n[1023-8*j -: 8] = 8'h80;
      end
    end
    if (s_axis_tlast && !extra_n) begin
      if (big) blk_n[63:0]    = len_n;
      else     blk_n[575:512] = len_n;
    end

    extra_blk = '0;
    if (marker_q) extra_blk[1023:1016] = 8'h80;
    if (type_q[1]) extra_blk[63:0]    = {byte_cnt[60:0], 3'b000};
    else           extra_blk[575:512] = {byte_cnt[60:0], 3'b000};
  end

  always_comb begin
    state_n = state;
    case (state)
      COLLECT:    if (beat_acc && complete) state_n = EMIT;
      EMIT:       if (blk_acc) state_n = extra_q ? EMIT_EXTRA : COLLECT;
      EMIT_EXTRA: if (blk_acc) state_n = COLLECT;
      default:    state_n = COLLECT;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) state <= COLLECT;
    else            state <= state_n;
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      alive    <= 1'b0;
      in_msg   <= 1'b0;
      type_q   <= 2'd0;
      tuser_q  <= '0;
      beat_idx <= 1'b0;
      byte_cnt <= 64'd0;
      blk      <= '0;
      last_q   <= 1'b0;
      extra_q  <= 1'b0;
      marker_q <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (beat_acc) begin
        blk      <= blk_n;
        byte_cnt <= cnt_n;
        beat_idx <= !complete;
        if (!in_msg) begin
          in_msg  <= 1'b1;
          type_q  <= s_axis_tuser[33:32];
          tuser_q <= M_AXIS_TUSER_WIDTH'(s_axis_tuser);
        end
        if (complete) begin
          last_q   <= s_axis_tlast && !extra_n;
          extra_q  <= extra_n;
          marker_q <= (p == bsize);
        end
      end
      if (blk_acc && (state == EMIT) && extra_q) begin
        blk     <= extra_blk;
        last_q  <= 1'b1;
        extra_q <= 1'b0;
      end
      if (msg_done) begin
        in_msg   <= 1'b0;
        type_q   <= 2'd0;
        beat_idx <= 1'b0;
        byte_cnt <= 64'd0;
      end
    end
  end

endmodule
`default_nettype wire
